cikis_paketleyici: RTL and testbench

Output packer that sits directly downstream of the task unit. It consumes the task unit's `etkin`/24-bit pixel stream and packs it into 32-bit words. Four 8-bit pixels go into each word for the filter tasks; one zero-extended 24-bit value goes into each word for the histogram tasks. Words pass through an internal first-word-fall-through FIFO to a valid/ready consumer (bus master or UART sender). The task unit cannot stall, so the input side has no backpressure; overflow is detected and flagged.

---
 rtl/cikis_paketleyici_pkg.sv | 26 ++
 rtl/cikis_paketleyici_fifo.sv | 64 ++++++
 rtl/cikis_paketleyici.sv | 130 +++++++++++++
 tb/tb_cikis_paketleyici.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/cikis_paketleyici_pkg.sv
// Shared types and constants for the output packer: FSM states, packing modes,
// word width and the lane-insert helper used by the pixel packer.
package cikis_paketleyici_pkg;

    localparam int PKT_KELIME_BIT = 32;
    localparam int PKT_PIKSEL_BIT = 24;

    localparam logic PKT_MOD_PIKSEL = 1'b0;
    localparam logic PKT_MOD_HIST   = 1'b1;

    typedef enum logic [1:0] {
        PKT_BOSTA  = 2'd0,
        PKT_TOPLA  = 2'd1,
        PKT_BOSALT = 2'd2
    } durum_e;

    // Places a byte into lane `serit` on top of the bytes already packed; upper lanes stay zero.
    function automatic logic [PKT_KELIME_BIT-1:0] serit_ekle(
        input logic [PKT_PIKSEL_BIT-1:0] paket,
        input logic [1:0]                serit,
        input logic [7:0]                bayt
    );
        return {8'h00, paket} | ({24'h000000, bayt} << {serit, 3'b000});
    endfunction

endpackage

// File: rtl/cikis_paketleyici_fifo.sv
// Synchronous first-word-fall-through FIFO. The caller only pushes when there
// is room (or a pop happens in the same cycle); there is no drop policy here.
module cikis_fifo #(
    parameter int GENISLIK = 32,
    parameter int DERINLIK = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          push_i,
    input  logic [GENISLIK-1:0]           veri_i,
    input  logic                          pop_i,
    output logic [GENISLIK-1:0]           veri_o,
    output logic                          dolu_o,
    output logic                          bos_o,
    output logic [$clog2(DERINLIK+1)-1:0] sayi_o
);

    localparam int AW = $clog2(DERINLIK);
    localparam int CW = $clog2(DERINLIK+1);

    logic [GENISLIK-1:0] mem_q [DERINLIK];
    logic [AW-1:0]       yaz_q, yaz_d;
    logic [AW-1:0]       oku_q, oku_d;
    logic [CW-1:0]       sayi_q, sayi_d;
    logic                pop_ok;

    assign pop_ok = pop_i && (sayi_q != '0);

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        yaz_d  = yaz_q;
        oku_d  = oku_q;
        sayi_d = sayi_q;
        if (push_i) yaz_d = yaz_q + 1'b1;
        if (pop_ok) oku_d = oku_q + 1'b1;
        case ({push_i, pop_ok})
            2'b10:   sayi_d = sayi_q + 1'b1;
            2'b01:   sayi_d = sayi_q - 1'b1;
            default: sayi_d = sayi_q;
        endcase
    end

    // NOTE: storage is reset too, so veri_o reads zero straight out of reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            yaz_q  <= '0;
            oku_q  <= '0;
            sayi_q <= '0;
            for (int i = 0; i < DERINLIK; i++) mem_q[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from pre-edge values.
            yaz_q  <= yaz_d;
            oku_q  <= oku_d;
            sayi_q <= sayi_d;
            if (push_i) mem_q[yaz_q] <= veri_i;
        end
    end

    assign veri_o = mem_q[oku_q];
    assign sayi_o = sayi_q;
    assign bos_o  = (sayi_q == '0);
    assign dolu_o = (sayi_q == CW'(DERINLIK));

endmodule

// File: rtl/cikis_paketleyici.sv
// Output packer: collects a frame of task-unit samples, packs them into 32-bit
// words (4 bytes or 1 zero-extended 24-bit value) and queues them for a valid/ready consumer.
module cikis_paketleyici
    import cikis_paketleyici_pkg::*;
#(
    parameter int FIFO_DERINLIK  = 16,
    parameter int CERCEVE_PIKSEL = 16384
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      basla_i,
    input  logic                      mod_i,
    input  logic                      etkin_i,
    input  logic [PKT_PIKSEL_BIT-1:0] pixel_i,
    output logic [PKT_KELIME_BIT-1:0] veri_o,
    output logic                      gecerli_o,
    input  logic                      hazir_i,
    output logic                      cerceve_bitti_o,
    output logic                      tasma_o,
    output logic                      mesgul_o
);

    localparam int SW = $clog2(CERCEVE_PIKSEL+1);
    localparam int CW = $clog2(FIFO_DERINLIK+1);

    durum_e                    durum_q, durum_d;
    logic                      mod_q, mod_d;
    logic [SW-1:0]             sayac_q, sayac_d;
    logic [1:0]                serit_q, serit_d;
    logic [PKT_PIKSEL_BIT-1:0] paket_q, paket_d;
    logic                      tasma_q, tasma_d;

    logic                      basla_kabul, ornek_al, son_ornek;
    logic                      push_iste, push_kabul, pop;
    logic [PKT_KELIME_BIT-1:0] kelime;
    logic                      fifo_dolu, fifo_bos;
    logic [CW-1:0]             fifo_sayi;

    assign basla_kabul = (durum_q == PKT_BOSTA) && basla_i;
    assign ornek_al    = (durum_q == PKT_TOPLA) && etkin_i;
    assign son_ornek   = (sayac_q == SW'(CERCEVE_PIKSEL - 1));
    assign pop         = gecerli_o && hazir_i;
    // A full FIFO still takes the word when the consumer frees a slot this cycle.
    assign push_kabul  = push_iste && (!fifo_dolu || pop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            durum_q <= PKT_BOSTA;
            mod_q   <= PKT_MOD_PIKSEL;
            sayac_q <= '0;
            serit_q <= '0;
            paket_q <= '0;
            tasma_q <= 1'b0;
        end else begin
            durum_q <= durum_d;
            mod_q   <= mod_d;
            sayac_q <= sayac_d;
            serit_q <= serit_d;
            paket_q <= paket_d;
            tasma_q <= tasma_d;
        end
    end

    always_comb begin
        durum_d = durum_q;
        case (durum_q)
            PKT_BOSTA:  if (basla_i) durum_d = PKT_TOPLA;
            PKT_TOPLA:  if (ornek_al && son_ornek) durum_d = PKT_BOSALT;
            PKT_BOSALT: if (fifo_bos) durum_d = PKT_BOSTA;
            default:    durum_d = PKT_BOSTA;
        endcase
    end

    always_comb begin
        mod_d     = mod_q;
        sayac_d   = sayac_q;
        serit_d   = serit_q;
        paket_d   = paket_q;
        tasma_d   = tasma_q;
        push_iste = 1'b0;
        kelime    = '0;
        if (basla_kabul) begin
            mod_d   = mod_i;
            sayac_d = '0;
            serit_d = '0;
            paket_d = '0;
            tasma_d = 1'b0;
        end else if (ornek_al) begin
            sayac_d = sayac_q + 1'b1;
            if (mod_q == PKT_MOD_HIST) begin
                kelime    = {8'h00, pixel_i};
                push_iste = 1'b1;
            end else begin
                kelime = serit_ekle(paket_q, serit_q, pixel_i[7:0]);
                if (serit_q == 2'd3 || son_ornek) begin
                    push_iste = 1'b1;
                    serit_d   = '0;
                    paket_d   = '0;
                end else begin
                    serit_d = serit_q + 1'b1;
                    paket_d = kelime[PKT_PIKSEL_BIT-1:0];
                end
            end
            if (push_iste && !push_kabul) tasma_d = 1'b1;
        end
    end

    always_comb begin
        mesgul_o        = (durum_q != PKT_BOSTA);
        cerceve_bitti_o = (durum_q == PKT_BOSALT) && fifo_bos;
        gecerli_o       = (fifo_sayi != '0);
        tasma_o         = tasma_q;
    end

    cikis_fifo #(
        .GENISLIK (PKT_KELIME_BIT),
        .DERINLIK (FIFO_DERINLIK)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .push_i (push_kabul),
        .veri_i (kelime),
        .pop_i  (pop),
        .veri_o (veri_o),
        .dolu_o (fifo_dolu),
        .bos_o  (fifo_bos),
        .sayi_o (fifo_sayi)
    );

endmodule

// File: tb/tb_cikis_paketleyici.sv
// Randomized bench for cikis_paketleyici against a frame-level queue model
// (bytes grouped by four, bounded FIFO occupancy, drop-on-full).
module tb_cikis_paketleyici;

    localparam int FD = 4;
    localparam int CP = 6;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        basla_i, mod_i, etkin_i, hazir_i;
    logic [23:0] pixel_i;
    logic [31:0] veri_o;
    logic        gecerli_o, cerceve_bitti_o, tasma_o, mesgul_o;

    cikis_paketleyici #(
        .FIFO_DERINLIK  (FD),
        .CERCEVE_PIKSEL (CP)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .basla_i         (basla_i),
        .mod_i           (mod_i),
        .etkin_i         (etkin_i),
        .pixel_i         (pixel_i),
        .veri_o          (veri_o),
        .gecerli_o       (gecerli_o),
        .hazir_i         (hazir_i),
        .cerceve_bitti_o (cerceve_bitti_o),
        .tasma_o         (tasma_o),
        .mesgul_o        (mesgul_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;

    task automatic denetle(input string etiket, input logic [31:0] gozlenen, input logic [31:0] beklenen);
        n_cmp++;
        if (gozlenen !== beklenen) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", etiket, gozlenen, beklenen, $time);
        end
    endtask

    // Reference model: frame phase flags, a byte accumulator and the word queue.
    logic [31:0] mq[$];
    logic [7:0]  m_bayt[$];
    bit          m_mesgul, m_bosalt, m_mod, m_tasma;
    int          m_sayi;
    int          bitti_adet;

    task automatic model_sifirla();
        mq.delete();
        m_bayt.delete();
        m_mesgul = 0; m_bosalt = 0; m_mod = 0; m_tasma = 0;
        m_sayi = 0;
    endtask

    task automatic cikis_denetle();
        bit bitti_bek;
        bitti_bek = m_bosalt && (mq.size() == 0);
        denetle("gecerli", {31'b0, gecerli_o}, {31'b0, mq.size() != 0});
        if (mq.size() != 0) denetle("veri", veri_o, mq[0]);
        denetle("tasma", {31'b0, tasma_o}, {31'b0, m_tasma});
        denetle("mesgul", {31'b0, mesgul_o}, {31'b0, m_mesgul});
        denetle("bitti", {31'b0, cerceve_bitti_o}, {31'b0, bitti_bek});
        if (cerceve_bitti_o) bitti_adet++;
    endtask

    task automatic model_adim(input bit b, input bit m, input bit e, input logic [23:0] p, input bit h);
        int          onceki;
        bit          pop, push, bitir;
        logic [31:0] w;
        onceki = mq.size();
        pop    = h && (onceki > 0);
        bitir  = m_bosalt && (onceki == 0);
        push   = 0;
        w      = '0;
        if (m_mesgul && !m_bosalt && e) begin
            m_sayi++;
            if (m_mod) begin
                push = 1;
                w    = {8'h00, p};
            end else begin
                m_bayt.push_back(p[7:0]);
                if (m_bayt.size() == 4 || m_sayi == CP) begin
                    foreach (m_bayt[i]) w = w | (32'(m_bayt[i]) << (8 * i));
                    m_bayt.delete();
                    push = 1;
                end
            end
            if (m_sayi == CP) m_bosalt = 1;
        end
        if (pop) void'(mq.pop_front());
        if (push) begin
            if (onceki < FD || pop) mq.push_back(w);
            else m_tasma = 1;
        end
        if (bitir) begin
            m_mesgul = 0;
            m_bosalt = 0;
        end else if (!m_mesgul && b) begin
            m_mesgul = 1;
            m_mod    = m;
            m_sayi   = 0;
            m_bayt.delete();
            m_tasma  = 0;
        end
    endtask

    task automatic tick(input bit b, input bit m, input bit e, input logic [23:0] p, input bit h);
        @(negedge clk_i);
        cikis_denetle();
        basla_i = b; mod_i = m; etkin_i = e; pixel_i = p; hazir_i = h;
        model_adim(b, m, e, p, h);
    endtask

    // hz_kip: 0 always ready, 1 random ready, 2 not ready for the first `tut` cycles.
    task automatic cerceve(input bit mod, input int hz_kip, input int tut, input bit sirali, input logic [23:0] taban);
        int          idx;
        bit          e, h, bitti;
        logic [23:0] p;
        idx        = 0;
        bitti      = 0;
        bitti_adet = 0;
        tick(1'b1, mod, 1'b0, 24'h0, 1'b1);
        for (int c = 0; c < 400; c++) begin
            e = (sirali || hz_kip == 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
            p = sirali ? taban + 24'(idx) : 24'($urandom);
            if (e) idx++;
            case (hz_kip)
                0:       h = 1'b1;
                1:       h = 1'($urandom_range(0, 1));
                default: h = (c >= tut);
            endcase
            tick(($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), e, p, h);
            if (!m_mesgul) begin
                bitti = 1;
                break;
            end
        end
        if (!bitti) denetle("zaman_asimi", 32'd1, 32'd0);
        tick(1'b0, 1'b0, 1'b0, 24'h0, 1'b1);
        denetle("bitti_sayisi", 32'(bitti_adet), 32'd1);
    endtask

    initial begin
        rst_i = 1'b1; basla_i = 0; mod_i = 0; etkin_i = 0; pixel_i = '0; hazir_i = 0;
        model_sifirla();
        #12;
        denetle("rst_veri", veri_o, 32'h0);
        denetle("rst_gecerli", {31'b0, gecerli_o}, 32'h0);
        denetle("rst_tasma", {31'b0, tasma_o}, 32'h0);
        denetle("rst_mesgul", {31'b0, mesgul_o}, 32'h0);
        denetle("rst_bitti", {31'b0, cerceve_bitti_o}, 32'h0);
        @(negedge clk_i) rst_i = 1'b0;

        cerceve(1'b0, 0, 0, 1'b1, 24'h000001);
        cerceve(1'b0, 0, 0, 1'b1, 24'h0000AA);
        cerceve(1'b1, 0, 0, 1'b1, 24'h01FFFF);
        cerceve(1'b1, 2, 30, 1'b1, 24'h000100);
        denetle("tasma_yapiskan", {31'b0, tasma_o}, 32'h1);
        cerceve(1'b1, 2, 4, 1'b1, 24'h000200);
        denetle("dolu_push_pop_tasma", {31'b0, tasma_o}, 32'h0);

        // Asynchronous reset in the middle of a pixel frame after three bytes.
        tick(1'b1, 1'b0, 1'b0, 24'h0, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b1, 24'(8'h50 + i), 1'b0);
        @(posedge clk_i);
        #2 rst_i = 1'b1;
        #1;
        denetle("arst_veri", veri_o, 32'h0);
        denetle("arst_gecerli", {31'b0, gecerli_o}, 32'h0);
        denetle("arst_mesgul", {31'b0, mesgul_o}, 32'h0);
        denetle("arst_bitti", {31'b0, cerceve_bitti_o}, 32'h0);
        model_sifirla();
        @(negedge clk_i) begin rst_i = 1'b0; etkin_i = 1'b0; end
        cerceve(1'b0, 0, 0, 1'b1, 24'h000011);

        for (int f = 0; f < 16; f++)
            cerceve(1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 20), 1'b0, 24'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
